scl_vtx: RTL and testbench
==========================

SCL_VTX -- requirements
Module: scl_vtx

Interface
REQ-001 SHALL have ports: clk_scl  in  1  single clock; all logic on rising edge.
REQ-002 SHALL have ports: rst_scl  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have ports: cfg_width  in  12  active pixels per line, 1..4095.
REQ-004 SHALL have ports: cfg_height  in  11  lines per frame, 1..2047.
REQ-005 SHALL have ports: cfg_hblank  in  8  idle cycles before each line, 0..255.
REQ-006 SHALL have ports: cfg_vblank  in  16  idle cycles before first line, 0..65535.
REQ-007 SHALL have ports: start  in  1  single-cycle frame request.
REQ-008 SHALL have ports: pix_valid  in  1, pix_ready  out  1, pix_r/pix_g/pix_b  in  8 each  upstream pixel handshake.
REQ-009 SHALL have ports: vtx_o_vsync, vtx_o_hsync, vtx_o_data_en  out  1 each; vtx_o_data_r/g/b  out  8 each  video stream to scaler input.
REQ-010 SHALL have ports: busy  out  1; frame_done  out  1 (pulse); underrun  out  1 (sticky).

Function
REQ-011 SHALL implement FSM IDLE -> VBLANK -> HBLANK -> ACTIVE -> (HBLANK | DONE) -> IDLE.
REQ-012 SHALL leave IDLE only when start=1; start in any other state ignored.
REQ-013 SHALL sample cfg_* on the start cycle; later cfg changes have no effect until next frame.
REQ-014 SHALL stay in VBLANK exactly cfg_vblank cycles (0 = skip directly to HBLANK).
REQ-015 SHALL stay in HBLANK exactly cfg_hblank cycles per line (0 = skip to ACTIVE).
REQ-016 SHALL drive pix_ready=1 only in ACTIVE; a pixel is accepted when pix_valid & pix_ready.
REQ-017 SHALL register outputs: accepted pixel appears on vtx_o_data_* with vtx_o_data_en=1 exactly one cycle after acceptance.
REQ-018 SHALL hold pixel counter when pix_valid=0 in ACTIVE, drive vtx_o_data_en=0 that cycle, and set underrun.
REQ-019 SHALL leave ACTIVE after cfg_width accepted pixels; line counter increments; after cfg_height lines go to DONE.
REQ-020 SHALL drive vtx_o_vsync=0 during VBLANK, vtx_o_hsync=0 during HBLANK, both 1 otherwise (registered, aligned with data).
REQ-021 SHALL hold vtx_o_data_r/g/b at last value when vtx_o_data_en=0.
REQ-022 SHALL pulse frame_done one cycle in DONE; busy=1 in every state except IDLE.
REQ-023 SHALL clear underrun only on reset or on accepted start.
REQ-024 SHALL size counters at 12/11/8/16 bits; no wrap occurs within legal config ranges.

Reset
REQ-025 SHALL on rst_scl=1 immediately force IDLE, counters 0, vsync=1, hsync=1, data_en=0, data_r/g/b=0, pix_ready=0, busy=0, frame_done=0, underrun=0.
REQ-026 SHALL abort a frame in progress on reset mid-frame; no frame_done is emitted for it.

Configuration
REQ-027 SHALL support macro SCL_VTX_PATTERN_EN: when defined, adds input cfg_pat (1 bit); cfg_pat=1 at start sources pixels from internal generator (r=x[7:0], g=y[7:0], b=x[7:0]^y[7:0]), ignores pix_valid, keeps pix_ready=0, never sets underrun.
REQ-028 SHALL without SCL_VTX_PATTERN_EN have no cfg_pat port and only the upstream pixel path.

Structure
REQ-029 SHALL place state enum and counter width constants in package scl_vtx_pkg.
REQ-030 SHALL place the pattern generator in sub-module scl_vtx_pat, instantiated only under SCL_VTX_PATTERN_EN.

Verification
REQ-031 SHALL cover: width=4, height=2, hblank=3, vblank=5, pix_valid=1 -> 5 vsync-low cycles, per line 3 hsync-low cycles then 4 data_en cycles, frame_done after 8 pixels, underrun=0.
REQ-032 SHALL cover: pix_valid low 2 cycles mid-line, width=4 -> data_en gap of 2 cycles, still 4 pixels out in order, underrun=1.
REQ-033 SHALL cover: hblank=0, vblank=0, width=1, height=1 -> single data_en pulse 2 cycles after start, frame_done next.
REQ-034 SHALL cover: rst_scl asserted during line 2 of 4 -> outputs at reset values same cycle, no frame_done, new start runs full frame.
REQ-035 SHALL cover: start repeated while busy, cfg_width changed mid-frame -> ignored, frame uses sampled width.
REQ-036 SHALL cover (macro defined): cfg_pat=1, width=3, height=2 -> pixels (0,0,0),(1,0,1),(2,0,2),(0,1,1),(1,1,0),(2,1,3).

Source files
------------

// File: rtl/scl_vtx_pkg.sv
// Shared types and constants for the scl_vtx video timing source.
//   state_t    : frame sequencer states
//   XWidth..   : counter widths for pixel, line, hblank and vblank counters
//   line_entry : first state of a line given the sampled hblank length
package scl_vtx_pkg;

    localparam int unsigned XWidth = 12;  // pixels per line
    localparam int unsigned YWidth = 11;  // lines per frame
    localparam int unsigned HWidth = 8;   // hblank cycles
    localparam int unsigned VWidth = 16;  // vblank cycles

    typedef enum logic [2:0] {
        StIdle,
        StVblank,
        StHblank,
        StActive,
        StDone
    } state_t;

    // A zero-length hblank goes straight to the active pixels of the line.
    function automatic state_t line_entry(input logic [HWidth-1:0] hblank);
        return (hblank != '0) ? StHblank : StActive;
    endfunction

endpackage

// File: rtl/scl_vtx_pat.sv
// Internal test pattern generator for scl_vtx.
// Ports:
//   x_lo, y_lo          : low 8 bits of the current pixel / line counters
//   pat_r, pat_g, pat_b : generated colour (r = x, g = y, b = x ^ y)
module scl_vtx_pat (
    input  logic [7:0] x_lo,
    input  logic [7:0] y_lo,
    output logic [7:0] pat_r,
    output logic [7:0] pat_g,
    output logic [7:0] pat_b
);

    assign pat_r = x_lo;
    assign pat_g = y_lo;
    assign pat_b = x_lo ^ y_lo;

endmodule

// File: rtl/scl_vtx.sv
// scl_vtx: frame timing source feeding a scaler input. On start it samples the
// configuration, emits vblank, then per line hblank followed by cfg_width pixels
// taken from the upstream valid/ready stream, and finally pulses frame_done.
//
// Optional feature macro: SCL_VTX_PATTERN_EN adds cfg_pat; when set at start,
// pixels come from the internal x/y pattern generator instead of upstream.
//
// Ports:
//   clk_scl, rst_scl        : clock (rising edge), async active-high reset
//   cfg_width/height        : active pixels per line / lines per frame
//   cfg_hblank/vblank       : idle cycles before each line / before first line
//   cfg_pat (macro only)    : select internal pattern for the next frame
//   start                   : frame request, honoured only when idle
//   pix_valid/ready/r/g/b   : upstream pixel handshake
//   vtx_o_*                 : registered video stream (sync, data enable, rgb)
//   busy, frame_done        : not idle / one-cycle end-of-frame pulse
//   underrun                : sticky, upstream had no pixel during active
module scl_vtx
    import scl_vtx_pkg::*;
(
    input  logic              clk_scl,
    input  logic              rst_scl,
    input  logic [XWidth-1:0] cfg_width,
    input  logic [YWidth-1:0] cfg_height,
    input  logic [HWidth-1:0] cfg_hblank,
    input  logic [VWidth-1:0] cfg_vblank,
`ifdef SCL_VTX_PATTERN_EN
    input  logic              cfg_pat,
`endif
    input  logic              start,
    input  logic              pix_valid,
    output logic              pix_ready,
    input  logic [7:0]        pix_r,
    input  logic [7:0]        pix_g,
    input  logic [7:0]        pix_b,
    output logic              vtx_o_vsync,
    output logic              vtx_o_hsync,
    output logic              vtx_o_data_en,
    output logic [7:0]        vtx_o_data_r,
    output logic [7:0]        vtx_o_data_g,
    output logic [7:0]        vtx_o_data_b,
    output logic              busy,
    output logic              frame_done,
    output logic              underrun
);

    state_t            state_q, state_d;
    logic [XWidth-1:0] width_q, width_d, x_q, x_d;
    logic [YWidth-1:0] height_q, height_d, y_q, y_d;
    logic [HWidth-1:0] hblank_q, hblank_d, hcnt_q, hcnt_d;
    logic [VWidth-1:0] vblank_q, vblank_d, vcnt_q, vcnt_d;
    logic              vsync_q, vsync_d, hsync_q, hsync_d;
    logic              de_q, de_d, fd_q, fd_d, underrun_q, underrun_d;
    logic [7:0]        r_q, r_d, g_q, g_d, b_q, b_d;

    logic              pat_mode;
    logic [7:0]        src_r, src_g, src_b;

`ifdef SCL_VTX_PATTERN_EN
    logic       pat_q, pat_d;
    logic [7:0] pat_r, pat_g, pat_b;

    scl_vtx_pat u_pat (
        .x_lo  (x_q[7:0]),
        .y_lo  (y_q[7:0]),
        .pat_r (pat_r),
        .pat_g (pat_g),
        .pat_b (pat_b)
    );

    always_ff @(posedge clk_scl or posedge rst_scl) begin
        if (rst_scl) begin
            pat_q <= 1'b0;
        end else begin
            pat_q <= pat_d;
        end
    end

    always_comb begin
        pat_d = pat_q;
        if (state_q == StIdle && start) begin
            pat_d = cfg_pat;
        end
    end

    assign pat_mode = pat_q;
    assign src_r    = pat_q ? pat_r : pix_r;
    assign src_g    = pat_q ? pat_g : pix_g;
    assign src_b    = pat_q ? pat_b : pix_b;
`else
    assign pat_mode = 1'b0;
    assign src_r    = pix_r;
    assign src_g    = pix_g;
    assign src_b    = pix_b;
`endif

    always_comb begin
        state_d    = state_q;
        width_d    = width_q;
        height_d   = height_q;
        hblank_d   = hblank_q;
        vblank_d   = vblank_q;
        x_d        = x_q;
        y_d        = y_q;
        hcnt_d     = hcnt_q;
        vcnt_d     = vcnt_q;
        underrun_d = underrun_q;
        r_d        = r_q;
        g_d        = g_q;
        b_d        = b_q;
        // Sync levels follow the state one cycle later, aligned with data.
        vsync_d    = 1'b1;
        hsync_d    = 1'b1;
        de_d       = 1'b0;
        fd_d       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    width_d    = cfg_width;
                    height_d   = cfg_height;
                    hblank_d   = cfg_hblank;
                    vblank_d   = cfg_vblank;
                    x_d        = '0;
                    y_d        = '0;
                    hcnt_d     = '0;
                    vcnt_d     = '0;
                    underrun_d = 1'b0;
                    // Decide from the live cfg values: the sampled copies land this edge.
                    state_d    = (cfg_vblank != '0) ? StVblank : line_entry(cfg_hblank);
                end
            end
            StVblank: begin
                vsync_d = 1'b0;
                if (vcnt_q == vblank_q - VWidth'(1)) begin
                    vcnt_d  = '0;
                    state_d = line_entry(hblank_q);
                end else begin
                    vcnt_d = vcnt_q + VWidth'(1);
                end
            end
            StHblank: begin
                hsync_d = 1'b0;
                if (hcnt_q == hblank_q - HWidth'(1)) begin
                    hcnt_d  = '0;
                    state_d = StActive;
                end else begin
                    hcnt_d = hcnt_q + HWidth'(1);
                end
            end
            StActive: begin
                if (pat_mode || pix_valid) begin
                    de_d = 1'b1;
                    r_d  = src_r;
                    g_d  = src_g;
                    b_d  = src_b;
                    if (x_q == width_q - XWidth'(1)) begin
                        x_d = '0;
                        if (y_q == height_q - YWidth'(1)) begin
                            state_d = StDone;
                        end else begin
                            y_d     = y_q + YWidth'(1);
                            state_d = line_entry(hblank_q);
                        end
                    end else begin
                        x_d = x_q + XWidth'(1);
                    end
                end else begin
                    underrun_d = 1'b1;
                end
            end
            StDone: begin
                // Registered so the pulse lands the cycle after the last data beat.
                fd_d    = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_scl or posedge rst_scl) begin
        if (rst_scl) begin
            state_q    <= StIdle;
            width_q    <= '0;
            height_q   <= '0;
            hblank_q   <= '0;
            vblank_q   <= '0;
            x_q        <= '0;
            y_q        <= '0;
            hcnt_q     <= '0;
            vcnt_q     <= '0;
            vsync_q    <= 1'b1;
            hsync_q    <= 1'b1;
            de_q       <= 1'b0;
            fd_q       <= 1'b0;
            underrun_q <= 1'b0;
            r_q        <= '0;
            g_q        <= '0;
            b_q        <= '0;
        end else begin
            state_q    <= state_d;
            width_q    <= width_d;
            height_q   <= height_d;
            hblank_q   <= hblank_d;
            vblank_q   <= vblank_d;
            x_q        <= x_d;
            y_q        <= y_d;
            hcnt_q     <= hcnt_d;
            vcnt_q     <= vcnt_d;
            vsync_q    <= vsync_d;
            hsync_q    <= hsync_d;
            de_q       <= de_d;
            fd_q       <= fd_d;
            underrun_q <= underrun_d;
            r_q        <= r_d;
            g_q        <= g_d;
            b_q        <= b_d;
        end
    end

    assign busy          = (state_q != StIdle);
    assign pix_ready     = (state_q == StActive) && !pat_mode;
    assign vtx_o_vsync   = vsync_q;
    assign vtx_o_hsync   = hsync_q;
    assign vtx_o_data_en = de_q;
    assign vtx_o_data_r  = r_q;
    assign vtx_o_data_g  = g_q;
    assign vtx_o_data_b  = b_q;
    assign frame_done    = fd_q;
    assign underrun      = underrun_q;

endmodule

// File: tb/tb_scl_vtx.sv
// Self-checking bench for scl_vtx: a source queue feeds the upstream pixel port,
// expected pixels go to a scoreboard, and a negedge monitor pops and compares on
// every data_en while counting sync-low cycles and frame_done pulses per frame.
module tb_scl_vtx;

    logic        clk_scl = 1'b0;
    logic        rst_scl;
    logic [11:0] cfg_width;
    logic [10:0] cfg_height;
    logic [7:0]  cfg_hblank;
    logic [15:0] cfg_vblank;
    logic        cfg_pat;
    logic        start;
    logic        pix_valid, pix_ready;
    logic [7:0]  pix_r, pix_g, pix_b;
    logic        vtx_o_vsync, vtx_o_hsync, vtx_o_data_en;
    logic [7:0]  vtx_o_data_r, vtx_o_data_g, vtx_o_data_b;
    logic        busy, frame_done, underrun;

    always #5 clk_scl = ~clk_scl;

    scl_vtx dut (
        .clk_scl       (clk_scl),
        .rst_scl       (rst_scl),
        .cfg_width     (cfg_width),
        .cfg_height    (cfg_height),
        .cfg_hblank    (cfg_hblank),
        .cfg_vblank    (cfg_vblank),
`ifdef SCL_VTX_PATTERN_EN
        .cfg_pat       (cfg_pat),
`endif
        .start         (start),
        .pix_valid     (pix_valid),
        .pix_ready     (pix_ready),
        .pix_r         (pix_r),
        .pix_g         (pix_g),
        .pix_b         (pix_b),
        .vtx_o_vsync   (vtx_o_vsync),
        .vtx_o_hsync   (vtx_o_hsync),
        .vtx_o_data_en (vtx_o_data_en),
        .vtx_o_data_r  (vtx_o_data_r),
        .vtx_o_data_g  (vtx_o_data_g),
        .vtx_o_data_b  (vtx_o_data_b),
        .busy          (busy),
        .frame_done    (frame_done),
        .underrun      (underrun)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [24:0] src_q[$];  // {valid, rgb}; valid=0 entries are bubbles
    logic [23:0] exp_q[$];

    int n_vs, n_hs, n_de, n_fd, n_rdy, first_de, last_de, max_gap, fd_cyc;

    always @(posedge clk_scl) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_scl);
        #2;
    endtask

    task automatic clear_stats();
        n_vs = 0; n_hs = 0; n_de = 0; n_fd = 0; n_rdy = 0;
        first_de = -1; last_de = -1; max_gap = 0; fd_cyc = -1;
    endtask

    task automatic push_pix(input logic [23:0] p);
        src_q.push_back({1'b1, p});
        exp_q.push_back(p);
    endtask

    task automatic push_bubble();
        src_q.push_back(25'h0);
    endtask

    task automatic set_cfg(input int w, input int h, input int hb, input int vb);
        cfg_width  = 12'(w);
        cfg_height = 11'(h);
        cfg_hblank = 8'(hb);
        cfg_vblank = 16'(vb);
    endtask

    task automatic do_start(output int sc);
        clear_stats();
        start = 1'b1;
        sc    = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int i = 0;
        while (n_fd == 0 && i < budget) begin
            @(negedge clk_scl);
            i++;
        end
        if (n_fd == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL frame_done_timeout: got no pulse within %0d cycles", budget);
        end
        tick();
        tick();
    endtask

    // Upstream source: pops on handshake, bubbles are consumed while ready.
    initial begin
        pix_valid = 1'b0;
        pix_r = '0; pix_g = '0; pix_b = '0;
        forever begin
            @(posedge clk_scl);
            if (pix_ready && src_q.size() > 0) void'(src_q.pop_front());
            #1;
            if (src_q.size() > 0) begin
                pix_valid = src_q[0][24];
                {pix_r, pix_g, pix_b} = src_q[0][23:0];
            end else begin
                pix_valid = 1'b0;
            end
        end
    end

    // Monitor / scoreboard.
    initial begin
        logic [23:0] e;
        forever begin
            @(negedge clk_scl);
            if (!rst_scl) begin
                if (!vtx_o_vsync) n_vs++;
                if (!vtx_o_hsync) n_hs++;
                if (pix_ready) n_rdy++;
                if (frame_done) begin
                    n_fd++;
                    fd_cyc = cyc;
                end
                if (vtx_o_data_en) begin
                    n_de++;
                    if (first_de < 0) first_de = cyc;
                    if (last_de >= 0 && cyc - last_de - 1 > max_gap) max_gap = cyc - last_de - 1;
                    last_de = cyc;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL sb_unexpected: got pixel %h with nothing expected",
                                 {vtx_o_data_r, vtx_o_data_g, vtx_o_data_b});
                    end else begin
                        e = exp_q.pop_front();
                        check("pixel", {8'h0, vtx_o_data_r, vtx_o_data_g, vtx_o_data_b}, {8'h0, e});
                    end
                end
            end
        end
    end

    initial begin
        int sc;
        rst_scl = 1'b1;
        start   = 1'b0;
        cfg_pat = 1'b0;
        set_cfg(4, 2, 3, 5);
        clear_stats();
        tick();
        tick();
        // Reset state
        check("rst_vsync", vtx_o_vsync, 1);
        check("rst_hsync", vtx_o_hsync, 1);
        check("rst_de", vtx_o_data_en, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", pix_ready, 0);
        check("rst_underrun", underrun, 0);
        rst_scl = 1'b0;
        tick();

        // Basic frame: 4x2, hblank 3, vblank 5
        for (int i = 0; i < 8; i++) push_pix(24'h102030 + 24'(i) * 24'h010101);
        tick();
        do_start(sc);
        check("t1_busy", busy, 1);
        wait_done(200);
        check("t1_vsync_low", n_vs, 5);
        check("t1_hsync_low", n_hs, 6);
        check("t1_de_count", n_de, 8);
        check("t1_fd_count", n_fd, 1);
        check("t1_first_de", first_de - sc, 10);
        check("t1_fd_cycle", fd_cyc - sc, 21);
        check("t1_underrun", underrun, 0);
        check("t1_idle", busy, 0);
        check("t1_drain", exp_q.size(), 0);

        // Upstream stalls 2 cycles mid-line
        set_cfg(4, 1, 1, 0);
        push_pix(24'hA00001);
        push_pix(24'hA00002);
        push_bubble();
        push_bubble();
        push_pix(24'hA00003);
        push_pix(24'hA00004);
        tick();
        do_start(sc);
        wait_done(100);
        check("t2_de_count", n_de, 4);
        check("t2_gap", max_gap, 2);
        check("t2_underrun", underrun, 1);
        check("t2_fd_count", n_fd, 1);
        check("t2_drain", exp_q.size(), 0);

        // Minimal frame, zero blanking; start also clears underrun
        set_cfg(1, 1, 0, 0);
        push_pix(24'h5A5A5A);
        tick();
        do_start(sc);
        check("t3_underrun_clr", underrun, 0);
        wait_done(50);
        check("t3_first_de", first_de - sc, 2);
        check("t3_de_count", n_de, 1);
        check("t3_fd_cycle", fd_cyc - sc, 3);
        check("t3_vsync_low", n_vs, 0);
        check("t3_drain", exp_q.size(), 0);

        // Reset during line 2 of 4
        set_cfg(4, 4, 2, 1);
        push_pix(24'hB00000);
        push_pix(24'hB00001);
        push_bubble();
        push_pix(24'hB00002);
        push_pix(24'hB00003);
        for (int i = 0; i < 12; i++) push_pix(24'hB10000 + 24'(i));
        tick();
        do_start(sc);
        while (cyc < sc + 12) tick();
        check("t4_busy_pre", busy, 1);
        check("t4_underrun_pre", underrun, 1);
        rst_scl = 1'b1;
        #1;
        check("t4_rst_vsync", vtx_o_vsync, 1);
        check("t4_rst_hsync", vtx_o_hsync, 1);
        check("t4_rst_de", vtx_o_data_en, 0);
        check("t4_rst_data", {vtx_o_data_r, vtx_o_data_g, vtx_o_data_b}, 0);
        check("t4_rst_ready", pix_ready, 0);
        check("t4_rst_busy", busy, 0);
        check("t4_rst_fd", frame_done, 0);
        check("t4_rst_underrun", underrun, 0);
        tick();
        rst_scl = 1'b0;
        src_q.delete();
        exp_q.delete();
        clear_stats();
        repeat (20) tick();
        check("t4_no_fd", n_fd, 0);
        check("t4_no_de", n_de, 0);
        set_cfg(2, 2, 1, 1);
        for (int i = 0; i < 4; i++) push_pix(24'hC00000 + 24'(i));
        tick();
        do_start(sc);
        wait_done(100);
        check("t4_new_de", n_de, 4);
        check("t4_new_fd", n_fd, 1);
        check("t4_new_vsync", n_vs, 1);
        check("t4_drain", exp_q.size(), 0);

        // Start while busy and cfg changes mid-frame are ignored
        set_cfg(3, 2, 2, 2);
        for (int i = 0; i < 6; i++) push_pix(24'hD00000 + 24'(i));
        tick();
        do_start(sc);
        tick();
        tick();
        set_cfg(1, 1, 0, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(100);
        check("t5_de_count", n_de, 6);
        check("t5_vsync_low", n_vs, 2);
        check("t5_hsync_low", n_hs, 4);
        check("t5_fd_count", n_fd, 1);
        check("t5_drain", exp_q.size(), 0);

`ifdef SCL_VTX_PATTERN_EN
        // Internal pattern source
        set_cfg(3, 2, 1, 0);
        cfg_pat = 1'b1;
        exp_q.push_back(24'h000000);
        exp_q.push_back(24'h010001);
        exp_q.push_back(24'h020002);
        exp_q.push_back(24'h000101);
        exp_q.push_back(24'h010100);
        exp_q.push_back(24'h020103);
        tick();
        do_start(sc);
        cfg_pat = 1'b0;
        wait_done(100);
        check("t6_de_count", n_de, 6);
        check("t6_ready", n_rdy, 0);
        check("t6_underrun", underrun, 0);
        check("t6_drain", exp_q.size(), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
